// File: rtl/pipe_stage_reg_pkg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg_pkg
// Shared constants for the elastic pipeline registers that sit on each stage
// boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   - datapath widths (DATA_WIDTH, REG_ADDR_WIDTH)
//   - ID/EX control bundle layout and its field encodings
//   - CTRL_NOP_ID_EX: packed control word with every write/memory enable off;
//     each instantiation passes its boundary's NOP word as CTRL_NOP
//   - per-boundary PAYLOAD_W / CTRL_W constants
//   - sat_inc32: saturating 32-bit increment used by the optional counters
// ----------------------------------------------------------------------------
package pipe_stage_reg_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  // ALU operation field encodings
  localparam logic [3:0] CTRL_ALU_ADD = 4'h0;
  localparam logic [3:0] CTRL_ALU_SUB = 4'h1;
  localparam logic [3:0] CTRL_ALU_AND = 4'h2;
  localparam logic [3:0] CTRL_ALU_OR  = 4'h3;
  localparam logic [3:0] CTRL_ALU_XOR = 4'h4;
  localparam logic [3:0] CTRL_ALU_SLT = 4'h5;
  localparam logic [3:0] CTRL_ALU_SLL = 4'h6;
  localparam logic [3:0] CTRL_ALU_SRL = 4'h7;

  // Single-bit control flags: 1 enables the action
  localparam logic CTRL_EN  = 1'b1;
  localparam logic CTRL_DIS = 1'b0;

  // ID/EX control bundle, 12 bits, MSB first
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic       reg_dst;
    logic [3:0] alu_op;
  } ctrl_id_ex_t;

  localparam int CTRL_ID_EX_W = $bits(ctrl_id_ex_t);

  // Bubble control: nothing writes, nothing touches memory, no redirect
  localparam ctrl_id_ex_t CTRL_NOP_ID_EX = '{
    reg_write:  CTRL_DIS,
    mem_to_reg: CTRL_DIS,
    mem_read:   CTRL_DIS,
    mem_write:  CTRL_DIS,
    branch:     CTRL_DIS,
    jump:       CTRL_DIS,
    alu_src:    CTRL_DIS,
    reg_dst:    CTRL_DIS,
    alu_op:     CTRL_ALU_ADD
  };

  // Per-boundary widths
  localparam int IF_ID_PAYLOAD_W  = DATA_WIDTH;                      // instruction word
  localparam int IF_ID_CTRL_W     = 1;                               // predicted-taken bit
  localparam int ID_EX_PAYLOAD_W  = 3 * DATA_WIDTH;                  // rs, rt, imm
  localparam int ID_EX_CTRL_W     = CTRL_ID_EX_W;
  localparam int EX_MEM_PAYLOAD_W = 2 * DATA_WIDTH + REG_ADDR_WIDTH; // alu, store data, rd
  localparam int EX_MEM_CTRL_W    = 4;
  localparam int MEM_WB_PAYLOAD_W = 2 * DATA_WIDTH + REG_ADDR_WIDTH; // load, alu, rd
  localparam int MEM_WB_CTRL_W    = 2;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// ----------------------------------------------------------------------------
// pipe_stage_cell
// One slot of the elastic pipeline register: valid, payload, ctrl, pc.
//   clk / rst       : clock, asynchronous active-high reset
//   flush_i         : kill the slot (valid=0, payload=0, ctrl=NOP), pc still shifts
//   load_i          : slot advances this edge (takes the predecessor's fields)
//   pred_*_i        : predecessor slot (or the block input for slot 0)
//   valid_o .. pc_o : registered slot contents
// An invalid slot always holds payload 0 and ctrl CTRL_NOP, so the outputs of
// the last slot need no extra masking.
// ----------------------------------------------------------------------------
module pipe_stage_cell
  import pipe_stage_reg_pkg::*;
#(
  parameter int                PAYLOAD_W = ID_EX_PAYLOAD_W,
  parameter int                CTRL_W    = ID_EX_CTRL_W,
  parameter int                PC_W      = DATA_WIDTH,
  parameter logic [CTRL_W-1:0] CTRL_NOP  = '0,
  parameter logic [PC_W-1:0]   PC_RESET  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 load_i,
  input  logic                 pred_valid_i,
  input  logic [PAYLOAD_W-1:0] pred_payload_i,
  input  logic [CTRL_W-1:0]    pred_ctrl_i,
  input  logic [PC_W-1:0]      pred_pc_i,
  output logic                 valid_o,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic [CTRL_W-1:0]    ctrl_o,
  output logic [PC_W-1:0]      pc_o
);

  logic                 valid_q,   valid_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [CTRL_W-1:0]    ctrl_q,    ctrl_d;
  logic [PC_W-1:0]      pc_q,      pc_d;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    ctrl_d    = ctrl_q;
    pc_d      = pc_q;
    if (flush_i) begin
      // flush beats a stall; pc keeps shifting so the slot tracks the fetch stream
      valid_d   = 1'b0;
      payload_d = '0;
      ctrl_d    = CTRL_NOP;
      pc_d      = pred_pc_i;
    end else if (load_i) begin
      // gate on pred valid: the block input is not scrubbed like slot contents are
      valid_d   = pred_valid_i;
      payload_d = pred_valid_i ? pred_payload_i : '0;
      ctrl_d    = pred_valid_i ? pred_ctrl_i    : CTRL_NOP;
      pc_d      = pred_pc_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      ctrl_q    <= CTRL_NOP;
      pc_q      <= PC_RESET;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      ctrl_q    <= ctrl_d;
      pc_q      <= pc_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;
  assign ctrl_o    = ctrl_q;
  assign pc_o      = pc_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
// Elastic DEPTH-slot pipeline register for a stage boundary. Slot 0 faces the
// upstream stage, slot DEPTH-1 drives the outputs directly.
//   clk, reset (async, active high), flush (kill all slots this cycle)
//   in_valid / in_ready / in_payload / in_ctrl / in_pc   : upstream side
//   out_valid / out_ready / out_payload / out_ctrl / out_pc : downstream side
//   occupancy : number of valid slots, kept in its own register
// Optional (macro PIPE_STATS_EN):
//   stall_cycles  : cycles with out_valid && !out_ready (saturating)
//   bubble_cycles : cycles with !out_valid (saturating)
//   Both clear on reset only.
// Backpressure ripples combinationally from out_ready to in_ready through
// DEPTH levels; an empty slot anywhere ahead lets the slots behind it move, so
// bubbles collapse instead of stalling upstream.
// ----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                PAYLOAD_W = ID_EX_PAYLOAD_W,
  parameter int                CTRL_W    = ID_EX_CTRL_W,
  parameter int                PC_W      = DATA_WIDTH,
  parameter int                DEPTH     = 1,
  parameter logic [CTRL_W-1:0] CTRL_NOP  = CTRL_W'(CTRL_NOP_ID_EX),
  parameter logic [PC_W-1:0]   PC_RESET  = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PAYLOAD_W-1:0]         in_payload,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [PC_W-1:0]              out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_STATS_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  bubble_cycles
`endif
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > 4) begin : g_depth_chk
    $error("pipe_stage_reg: DEPTH must be 1..4");
  end

  // Slot contents, index 0 = input side
  logic [DEPTH-1:0]                slot_vld;
  logic [DEPTH-1:0][PAYLOAD_W-1:0] slot_payload;
  logic [DEPTH-1:0][CTRL_W-1:0]    slot_ctrl;
  logic [DEPTH-1:0][PC_W-1:0]      slot_pc;

  // What each slot would load: the block input for slot 0, else the slot behind
  logic [DEPTH-1:0]                pred_vld;
  logic [DEPTH-1:0][PAYLOAD_W-1:0] pred_payload;
  logic [DEPTH-1:0][CTRL_W-1:0]    pred_ctrl;
  logic [DEPTH-1:0][PC_W-1:0]      pred_pc;

  logic [DEPTH:0]   adv;
  logic             accept;
  logic             drain;
  logic [OCC_W-1:0] occ_q, occ_d;

  // A slot may move when it is empty or the slot ahead of it moves
  always_comb begin
    adv        = '0;
    adv[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i] = !slot_vld[i] || adv[i+1];
    end
  end

  assign in_ready = adv[0] && !flush;
  assign accept   = in_valid && in_ready;
  assign drain    = slot_vld[DEPTH-1] && out_ready;

  always_comb begin
    pred_vld        = '0;
    pred_payload    = '0;
    pred_ctrl       = '0;
    pred_pc         = '0;
    pred_vld[0]     = accept;
    pred_payload[0] = in_payload;
    pred_ctrl[0]    = in_ctrl;
    pred_pc[0]      = in_pc;
    for (int i = 1; i < DEPTH; i++) begin
      pred_vld[i]     = slot_vld[i-1];
      pred_payload[i] = slot_payload[i-1];
      pred_ctrl[i]    = slot_ctrl[i-1];
      pred_pc[i]      = slot_pc[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    pipe_stage_cell #(
      .PAYLOAD_W (PAYLOAD_W),
      .CTRL_W    (CTRL_W),
      .PC_W      (PC_W),
      .CTRL_NOP  (CTRL_NOP),
      .PC_RESET  (PC_RESET)
    ) u_cell (
      .clk            (clk),
      .rst            (reset),
      .flush_i        (flush),
      .load_i         (adv[i]),
      .pred_valid_i   (pred_vld[i]),
      .pred_payload_i (pred_payload[i]),
      .pred_ctrl_i    (pred_ctrl[i]),
      .pred_pc_i      (pred_pc[i]),
      .valid_o        (slot_vld[i]),
      .payload_o      (slot_payload[i]),
      .ctrl_o         (slot_ctrl[i]),
      .pc_o           (slot_pc[i])
    );
  end

  // Occupancy tracks entries in minus entries out; internal bubble moves
  // never change the count.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(accept) - OCC_W'(drain);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy   = occ_q;
  assign out_valid   = slot_vld[DEPTH-1];
  assign out_payload = slot_payload[DEPTH-1];
  assign out_ctrl    = slot_ctrl[DEPTH-1];
  assign out_pc      = slot_pc[DEPTH-1];

`ifdef PIPE_STATS_EN
  logic [31:0] stall_q,  stall_d;
  logic [31:0] bubble_q, bubble_d;

  // Flush does not clear these; the flush cycle counts by its pre-edge state
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready) stall_d  = sat_inc32(stall_q);
    if (!out_valid)              bubble_d = sat_inc32(bubble_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign bubble_cycles = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Two instances: k=0 is DEPTH=1 with default NOP/PC reset, k=1 is DEPTH=3 with
// a non-zero NOP word and PC reset value. A slot-level reference model follows
// the boundary's rules and is compared against both DUTs every falling edge;
// directed sequences add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  typedef struct packed {
    logic        v;
    logic [95:0] p;
    logic [11:0] c;
    logic [31:0] pc;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fl   [2];
  logic        iv   [2];
  logic        ir   [2];
  logic        ordy [2];
  logic        ov   [2];
  logic [95:0] ipay [2];
  logic [95:0] opay [2];
  logic [11:0] ictl [2];
  logic [11:0] octl [2];
  logic [31:0] ipc  [2];
  logic [31:0] opc  [2];
  logic [0:0]  occ1;
  logic [1:0]  occ3;
`ifdef PIPE_STATS_EN
  logic [31:0] stl [2];
  logic [31:0] bub [2];
  int unsigned mst [2];
  int unsigned mbu [2];
  logic [31:0] s0, b0;
`endif

  int checks = 0;
  int errors = 0;

  slot_t m [2][4];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DEPTH(1)) u1 (
    .clk(clk), .reset(rst), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_payload(ipay[0]), .in_ctrl(ictl[0]), .in_pc(ipc[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_payload(opay[0]), .out_ctrl(octl[0]), .out_pc(opc[0]),
    .occupancy(occ1)
`ifdef PIPE_STATS_EN
    , .stall_cycles(stl[0]), .bubble_cycles(bub[0])
`endif
  );

  pipe_stage_reg #(.DEPTH(3), .CTRL_NOP(12'hA5A), .PC_RESET(32'hBFC0_0000)) u3 (
    .clk(clk), .reset(rst), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_payload(ipay[1]), .in_ctrl(ictl[1]), .in_pc(ipc[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_payload(opay[1]), .out_ctrl(octl[1]), .out_pc(opc[1]),
    .occupancy(occ3)
`ifdef PIPE_STATS_EN
    , .stall_cycles(stl[1]), .bubble_cycles(bub[1])
`endif
  );

  // ---------------- reference model ----------------
  function automatic int dp(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [11:0] nop(int k);
    return (k == 0) ? 12'h000 : 12'hA5A;
  endfunction

  function automatic logic [31:0] prst(int k);
    return (k == 0) ? 32'h0 : 32'hBFC0_0000;
  endfunction

  // Slot i can move if the head is drained or any slot from i forward is empty
  function automatic bit m_adv(int k, int i);
    bit r = ordy[k];
    for (int j = i; j < dp(k); j++) if (!m[k][j].v) r = 1'b1;
    return r;
  endfunction

  function automatic bit m_rdy(int k);
    return m_adv(k, 0) && !fl[k];
  endfunction

  function automatic int m_occ(int k);
    int n = 0;
    for (int j = 0; j < dp(k); j++) if (m[k][j].v) n++;
    return n;
  endfunction

  function automatic slot_t m_next(int k, int i);
    slot_t pred, cur;
    cur = m[k][i];
    if (i >= dp(k)) return cur;
    if (i == 0) begin
      pred.v  = iv[k] && m_rdy(k);
      pred.p  = ipay[k];
      pred.c  = ictl[k];
      pred.pc = ipc[k];
    end else begin
      pred = m[k][i-1];
    end
    if (fl[k]) return '{v:1'b0, p:96'h0, c:nop(k), pc:pred.pc};
    if (!m_adv(k, i)) return cur;
    if (pred.v) return pred;
    return '{v:1'b0, p:96'h0, c:nop(k), pc:pred.pc};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++) m[k][i] <= '{v:1'b0, p:96'h0, c:nop(k), pc:prst(k)};
`ifdef PIPE_STATS_EN
        mst[k] <= 0;
        mbu[k] <= 0;
`endif
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++) m[k][i] <= m_next(k, i);
`ifdef PIPE_STATS_EN
        if (m[k][dp(k)-1].v && !ordy[k]) mst[k] <= mst[k] + 1;
        if (!m[k][dp(k)-1].v)            mbu[k] <= mbu[k] + 1;
`endif
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      slot_t hd;
      hd = m[k][dp(k)-1];
      chk($sformatf("d%0d_out_valid", dp(k)),   ov[k],   hd.v);
      chk($sformatf("d%0d_out_payload", dp(k)), opay[k], hd.p);
      chk($sformatf("d%0d_out_ctrl", dp(k)),    octl[k], hd.c);
      chk($sformatf("d%0d_out_pc", dp(k)),      opc[k],  hd.pc);
      chk($sformatf("d%0d_in_ready", dp(k)),    ir[k],   rst ? ir[k] : m_rdy(k));
      chk($sformatf("d%0d_occupancy", dp(k)),   (k == 0) ? {1'b0, occ1} : occ3, m_occ(k));
`ifdef PIPE_STATS_EN
      chk($sformatf("d%0d_stall", dp(k)),  stl[k], mst[k]);
      chk($sformatf("d%0d_bubble", dp(k)), bub[k], mbu[k]);
`endif
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      fl[k] = 0; iv[k] = 0; ordy[k] = 0; ipay[k] = '0; ictl[k] = '0; ipc[k] = '0;
    end
    tick; tick;
    chk("rst_out_valid", ov[1], 0);
    chk("rst_out_ctrl", octl[1], 12'hA5A);
    chk("rst_out_pc", opc[1], 32'hBFC0_0000);
    chk("rst_out_payload", opay[1], 0);
    chk("rst_occupancy", occ3, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready_d3", ir[1], 1);
    chk("rst_in_ready_d1", ir[0], 1);

    // DEPTH=1 back-to-back pass-through
    ordy[0] = 1; iv[0] = 1; ictl[0] = 12'h123;
    for (int n = 1; n <= 3; n++) begin
      ipc[0]  = 32'(n * 4);
      ipay[0] = 96'hA0 + 96'(n);
      tick;
      chk("d1_pc", opc[0], 32'(n * 4));
      chk("d1_valid", ov[0], 1);
      chk("d1_occ", occ1, 1);
      chk("d1_ctrl", octl[0], 12'h123);
      chk("d1_payload", opay[0], 96'hA0 + 96'(n));
    end
    iv[0] = 0;
    tick;
    chk("d1_idle_valid", ov[0], 0);
    chk("d1_idle_ctrl", octl[0], 12'h000);
    chk("d1_idle_payload", opay[0], 0);

    // DEPTH=3 fill under backpressure, then drain
    ordy[1] = 0; iv[1] = 1; ictl[1] = 12'h321;
    for (int n = 0; n < 3; n++) begin
      ipay[1] = 96'h1000 + 96'(n);
      ipc[1]  = 32'h100 + 32'(n * 4);
      tick;
    end
    ipay[1] = 96'h1003; ipc[1] = 32'h10C;
    chk("full_in_ready", ir[1], 0);
    chk("full_occ", occ3, 3);
    chk("full_head", opay[1], 96'h1000);
    tick; tick;
    chk("hold_in_ready", ir[1], 0);
    chk("hold_head", opay[1], 96'h1000);
    ordy[1] = 1;
    #1;
    chk("drain_in_ready", ir[1], 1);
    tick;
    chk("drain1_payload", opay[1], 96'h1001);
    chk("drain1_occ", occ3, 3);
    iv[1] = 0;
    tick;
    chk("drain2_payload", opay[1], 96'h1002);
    chk("drain2_occ", occ3, 2);
    tick;
    chk("drain3_payload", opay[1], 96'h1003);
    chk("drain3_pc", opc[1], 32'h10C);
    chk("drain3_occ", occ3, 1);
    tick;
    chk("empty_valid", ov[1], 0);
    chk("empty_ctrl", octl[1], 12'hA5A);
    chk("empty_occ", occ3, 0);

    // Bubble collapse behind a stalled head
    ordy[1] = 0; iv[1] = 1; ipay[1] = 96'h2000;
    tick;
    iv[1] = 0;
    tick; tick;
    chk("bub_head_valid", ov[1], 1);
    chk("bub_head_payload", opay[1], 96'h2000);
    chk("bub_occ1", occ3, 1);
    chk("bub_in_ready", ir[1], 1);
    iv[1] = 1; ipay[1] = 96'h2001;
    tick;
    chk("bub_occ2", occ3, 2);
    chk("bub_head_kept", opay[1], 96'h2000);
    iv[1] = 0;

    // Flush with occupancy 2 and an input offered
    fl[1] = 1; iv[1] = 1; ipay[1] = 96'h2002; ipc[1] = 32'h40;
    #1;
    chk("flush_in_ready", ir[1], 0);
    tick;
    fl[1] = 0; iv[1] = 0; ipc[1] = 32'h99;
    chk("flush_valid", ov[1], 0);
    chk("flush_ctrl", octl[1], 12'hA5A);
    chk("flush_payload", opay[1], 0);
    chk("flush_occ", occ3, 0);
    tick; tick;
    chk("flush_pc_shift", opc[1], 32'h40);
    chk("flush_not_accepted", ov[1], 0);

    // Async reset mid-cycle while full
    iv[1] = 1;
    for (int n = 0; n < 3; n++) begin
      ipay[1] = 96'h3000 + 96'(n);
      tick;
    end
    iv[1] = 0;
    chk("prefill_occ", occ3, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", ov[1], 0);
    chk("arst_payload", opay[1], 0);
    chk("arst_ctrl", octl[1], 12'hA5A);
    chk("arst_pc", opc[1], 32'hBFC0_0000);
    chk("arst_occ", occ3, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    iv[1] = 1; ipay[1] = 96'h4000; ordy[1] = 1;
    tick;
    iv[1] = 0;
    chk("resume_occ", occ3, 1);
    tick; tick;
    chk("resume_valid", ov[1], 1);
    chk("resume_payload", opay[1], 96'h4000);

`ifdef PIPE_STATS_EN
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("stat_rst_stall", stl[1], 0);
    s0 = stl[1]; b0 = bub[1];
    iv[1] = 1; ordy[1] = 0; ipay[1] = 96'h5000;
    tick;
    iv[1] = 0;
    tick; tick;
    for (int n = 0; n < 5; n++) tick;
    chk("stat_stall5", stl[1] - s0, 5);
    chk("stat_bubble3", bub[1] - b0, 3);
    fl[1] = 1;
    tick;
    fl[1] = 0;
    chk("stat_flush_stall", stl[1] - s0, 6);
    chk("stat_flush_bubble", bub[1] - b0, 3);
`endif

    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
